// File: rtl/tdm_demux_pkg.sv
// tdm_demux shared types and constants.
// State encoding, select-width helper and error-counter width.
package tdm_demux_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int ERR_CNT_W = 8;

  function automatic int SEL_W(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_demux_decoder1_n.sv
// One-hot write-enable decoder for the staging slots.
// Converts a slot index plus enable into N enables.
module decoder1_n #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [SW-1:0] sel,
  input  logic          en,
  output logic [N-1:0]  onehot
);

  // one enable per slot, at most one set
  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = en && (sel == SW'(i));
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer with frame-sync tracking.
// Optional saturating error counter: define TDM_DEMUX_ERR_CNT_EN.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  localparam int SW      = SEL_W(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_sync,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      out_valid,
  output logic [SW-1:0]             sel,
  output logic                      locked,
  output logic                      sync_err
`ifdef TDM_DEMUX_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]      err_cnt
`endif
);

  localparam logic [SW-1:0] LAST = SW'(CHANNELS - 1);

  state_t                      state;
  logic [CHANNELS*WIDTH-1:0]   stg_q;
  logic [CHANNELS*WIDTH-1:0]   frame_nxt;
  logic [CHANNELS-1:0]         wr_oh;
  logic                        slot0;
  logic                        hunt_go;
  logic                        lock_ok;
  logic                        early;
  logic                        miss;
  logic                        wr_en;
  logic [SW-1:0]               wr_sel;
  logic                        done;

  // classify the accepted sample against the expected slot
  always_comb begin
    slot0   = (sel == '0);
    hunt_go = in_valid && (state == HUNT) && in_sync;
    lock_ok = in_valid && (state == LOCK) && (in_sync == slot0);
    early   = in_valid && (state == LOCK) && in_sync && !slot0;
    miss    = in_valid && (state == LOCK) && !in_sync && slot0;
    wr_en   = hunt_go || lock_ok || early;
    wr_sel  = in_sync ? '0 : sel;
    done    = wr_en && (wr_sel == LAST);
  end

  decoder1_n #(
    .N  (CHANNELS),
    .SW (SW)
  ) u_dec (
    .sel    (wr_sel),
    .en     (wr_en),
    .onehot (wr_oh)
  );

  // staging contents with the incoming sample merged in
  always_comb begin
    frame_nxt = stg_q;
    for (int k = 0; k < CHANNELS; k++) begin
      if (wr_oh[k]) frame_nxt[k*WIDTH +: WIDTH] = in_data;
    end
  end

  // state, slot pointer, staging and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      sel       <= '0;
      stg_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      out_valid <= done;
      sync_err  <= early || miss;
      if (wr_en) begin
        stg_q <= frame_nxt;
        sel   <= (wr_sel == LAST) ? '0 : wr_sel + SW'(1);
      end
      if (done) out_data <= frame_nxt;
      if (hunt_go) state <= LOCK;
      if (miss) begin
        state <= HUNT;
        sel   <= '0;
      end
    end
  end

  assign locked = (state == LOCK);

`ifdef TDM_DEMUX_ERR_CNT_EN
  // saturating count of sync violations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if ((early || miss) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux (CHANNELS=4, WIDTH=8).
// Reference model tracks the partial frame as a queue.
module tb_tdm_demux;

  localparam int C = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_sync = 1'b0;
  logic [C*W-1:0] out_data;
  logic           out_valid;
  logic [1:0]     sel;
  logic           locked;
  logic           sync_err;
`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [7:0]     err_cnt;
`endif

  int checks = 0;
  int passed = 0;

  logic [W-1:0]   m_part[$];
  logic           m_lock;
  logic [C*W-1:0] m_frame;
  logic           exp_ov;
  logic           exp_err;
  logic [1:0]     exp_sel;
  int             m_errcnt;

  tdm_demux #(.CHANNELS(C), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sync   (in_sync),
    .out_data  (out_data),
    .out_valid (out_valid),
    .sel       (sel),
    .locked    (locked),
    .sync_err  (sync_err)
`ifdef TDM_DEMUX_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_part.delete();
    m_lock   = 1'b0;
    m_frame  = '0;
    exp_ov   = 1'b0;
    exp_err  = 1'b0;
    exp_sel  = '0;
    m_errcnt = 0;
  endtask

  task automatic drive(input logic v, input logic s, input logic [W-1:0] d);
    @(negedge clk);
    in_valid = v;
    in_sync  = s;
    in_data  = d;
    exp_ov   = 1'b0;
    exp_err  = 1'b0;
    if (v) begin
      if (!m_lock) begin
        if (s) begin
          m_lock = 1'b1;
          m_part = '{d};
        end
      end else if (s) begin
        if (m_part.size() != 0) exp_err = 1'b1;
        m_part = '{d};
      end else if (m_part.size() == 0) begin
        exp_err = 1'b1;
        m_lock  = 1'b0;
      end else begin
        m_part.push_back(d);
      end
      if (m_lock && m_part.size() == C) begin
        for (int k = 0; k < C; k++) m_frame[k*W +: W] = m_part[k];
        exp_ov = 1'b1;
        m_part.delete();
      end
      if (exp_err && m_errcnt < 255) m_errcnt++;
    end
    exp_sel = m_lock ? 2'(m_part.size()) : 2'd0;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if ({out_valid, sync_err, locked, sel, out_data} !== '0) begin
      $display("FAIL reset: ov=%0b err=%0b lk=%0b sel=%0d data=%h want all 0",
               out_valid, sync_err, locked, sel, out_data);
    end else passed++;
`ifdef TDM_DEMUX_ERR_CNT_EN
    checks++;
    if (err_cnt !== 8'd0) $display("FAIL reset_errcnt: got %0d want 0", err_cnt);
    else passed++;
`endif
  endtask

  task automatic test_clean();
    logic [W-1:0] d[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 0, d[i]);
      checks++;
      if ({out_valid, sync_err, locked, sel, out_data} !==
          {exp_ov, exp_err, m_lock, exp_sel, m_frame}) begin
        $display("FAIL clean[%0d]: got ov=%0b err=%0b lk=%0b sel=%0d data=%h want ov=%0b err=%0b lk=%0b sel=%0d data=%h",
                 i, out_valid, sync_err, locked, sel, out_data,
                 exp_ov, exp_err, m_lock, exp_sel, m_frame);
      end else passed++;
    end
    checks++;
    if (out_data !== 32'h44332211) $display("FAIL clean_frame: got %h want 44332211", out_data);
    else passed++;
  endtask

  task automatic test_stalls();
    logic [W-1:0] d[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int pulses = 0;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < 4; g++) begin
        if (g == 0) drive(1'b1, i == 0, d[i]);
        else drive(1'b0, 1'b1, 8'hFF);
        if (out_valid) pulses++;
        checks++;
        if ({out_valid, sync_err, locked, sel, out_data} !==
            {exp_ov, exp_err, m_lock, exp_sel, m_frame}) begin
          $display("FAIL stalls[%0d.%0d]: got ov=%0b err=%0b lk=%0b sel=%0d data=%h want ov=%0b err=%0b lk=%0b sel=%0d data=%h",
                   i, g, out_valid, sync_err, locked, sel, out_data,
                   exp_ov, exp_err, m_lock, exp_sel, m_frame);
        end else passed++;
      end
    end
    checks++;
    if (pulses != 1 || out_data !== 32'h44332211)
      $display("FAIL stalls_frame: got pulses=%0d data=%h want 1 44332211", pulses, out_data);
    else passed++;
  endtask

  task automatic test_early_sync();
    logic [W-1:0] d[6] = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
    logic         s[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int errs = 0;
    int frames = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, s[i], d[i]);
      errs += int'(sync_err);
      frames += int'(out_valid);
      checks++;
      if ({out_valid, sync_err, locked, sel, out_data} !==
          {exp_ov, exp_err, m_lock, exp_sel, m_frame}) begin
        $display("FAIL early[%0d]: got ov=%0b err=%0b lk=%0b sel=%0d data=%h want ov=%0b err=%0b lk=%0b sel=%0d data=%h",
                 i, out_valid, sync_err, locked, sel, out_data,
                 exp_ov, exp_err, m_lock, exp_sel, m_frame);
      end else passed++;
    end
    checks++;
    if (errs != 1 || frames != 1 || out_data !== 32'hB3B2B1B0)
      $display("FAIL early_frame: got errs=%0d frames=%0d data=%h want 1 1 b3b2b1b0",
               errs, frames, out_data);
    else passed++;
  endtask

  task automatic test_missing_sync();
    logic [W-1:0] d[8] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h55, 8'h56, 8'h57, 8'h58};
    logic         s[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, s[i], d[i]);
      checks++;
      if ({out_valid, sync_err, locked, sel, out_data} !==
          {exp_ov, exp_err, m_lock, exp_sel, m_frame}) begin
        $display("FAIL missing[%0d]: got ov=%0b err=%0b lk=%0b sel=%0d data=%h want ov=%0b err=%0b lk=%0b sel=%0d data=%h",
                 i, out_valid, sync_err, locked, sel, out_data,
                 exp_ov, exp_err, m_lock, exp_sel, m_frame);
      end else passed++;
    end
    checks++;
    if (locked !== 1'b0 || sel !== 2'd0 || out_data !== 32'h64636261)
      $display("FAIL missing_state: got lk=%0b sel=%0d data=%h want 0 0 64636261",
               locked, sel, out_data);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] d[4] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    drive(1'b1, 1'b1, 8'h01);
    drive(1'b1, 1'b0, 8'h02);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, sync_err, locked, sel, out_data} !== '0)
      $display("FAIL reset_mid: ov=%0b err=%0b lk=%0b sel=%0d data=%h want all 0",
               out_valid, sync_err, locked, sel, out_data);
    else passed++;
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 0, d[i]);
      checks++;
      if ({out_valid, sync_err, locked, sel, out_data} !==
          {exp_ov, exp_err, m_lock, exp_sel, m_frame}) begin
        $display("FAIL reset_mid[%0d]: got ov=%0b err=%0b lk=%0b sel=%0d data=%h want ov=%0b err=%0b lk=%0b sel=%0d data=%h",
                 i, out_valid, sync_err, locked, sel, out_data,
                 exp_ov, exp_err, m_lock, exp_sel, m_frame);
      end else passed++;
    end
    checks++;
    if (out_data !== 32'h0D0C0B0A) $display("FAIL reset_mid_frame: got %h want 0d0c0b0a", out_data);
    else passed++;
  endtask

  task automatic test_random();
    int bad = 0;
    logic v;
    logic s;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) == 0) s = 1'($urandom);
      else s = (m_part.size() == 0);
      drive(v, s, 8'($urandom));
      checks++;
      if ({out_valid, sync_err, locked, sel, out_data} !==
          {exp_ov, exp_err, m_lock, exp_sel, m_frame}) begin
        bad++;
        if (bad < 10)
          $display("FAIL random[%0d]: got ov=%0b err=%0b lk=%0b sel=%0d data=%h want ov=%0b err=%0b lk=%0b sel=%0d data=%h",
                   i, out_valid, sync_err, locked, sel, out_data,
                   exp_ov, exp_err, m_lock, exp_sel, m_frame);
      end else passed++;
`ifdef TDM_DEMUX_ERR_CNT_EN
      checks++;
      if (err_cnt !== 8'(m_errcnt)) begin
        bad++;
        if (bad < 10) $display("FAIL random_errcnt[%0d]: got %0d want %0d", i, err_cnt, m_errcnt);
      end else passed++;
`endif
    end
  endtask

`ifdef TDM_DEMUX_ERR_CNT_EN
  task automatic test_err_sat();
    apply_reset();
    for (int n = 0; n < 300; n++) begin
      drive(1'b1, 1'b1, 8'h10);
      for (int k = 1; k < C; k++) drive(1'b1, 1'b0, 8'(k));
      drive(1'b1, 1'b0, 8'hEE);
    end
    checks++;
    if (err_cnt !== 8'd255 || m_errcnt != 255)
      $display("FAIL err_sat: got %0d want 255", err_cnt);
    else passed++;
    drive(1'b1, 1'b1, 8'h10);
    drive(1'b1, 1'b1, 8'h10);
    checks++;
    if (err_cnt !== 8'd255) $display("FAIL err_hold: got %0d want 255", err_cnt);
    else passed++;
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_clean();
    test_stalls();
    test_early_sync();
    test_missing_sync();
    test_reset_mid();
    test_random();
`ifdef TDM_DEMUX_ERR_CNT_EN
    test_err_sat();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: receives one serial stream of interleaved channel samples, with a frame-sync marker on channel 0, and fans it out into CHANNELS parallel registered words. It is the receiving end of the channel-interleaving path built from the team's mux primitives. Its outputs present one complete, stable frame at a time, with a one-cycle frame strobe.

## Interface
- CHANNELS, default 4: number of interleaved channels; legal range is 1..16.
- WIDTH, default 8: bits per sample.
- clk  input  1: rising-edge clock.
- rst_n  input  1: asynchronous, active-low reset.
- in_valid  input  1: in_data/in_sync are accepted on a rising edge while high.
- in_data  input  WIDTH: sample for the current slot.
- in_sync  input  1: marks the channel-0 sample of a frame; ignored when in_valid=0.
- out_data  output  CHANNELS*WIDTH: last complete frame; channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  1: one-cycle pulse when out_data is updated.
- sel  output  clog2(CHANNELS) (minimum 1): slot index expected for the next accepted sample.
- locked  output  1: high in state LOCK.
- sync_err  output  1: one-cycle pulse on a sync violation.
- err_cnt  output  8: present only with TDM_DEMUX_ERR_CNT_EN.

## Operation
- There are two states: HUNT and LOCK. Reset enters HUNT.
- **HUNT**
  - Accepted samples with in_sync=0 are discarded.
  - An accepted sample with in_sync=1 is written to staging slot 0, sets sel=1 (mod CHANNELS) and moves to LOCK.
- **LOCK, normal sample** (in_sync=1 when sel==0, in_sync=0 otherwise)
  - in_data is written to staging slot sel.
  - sel increments and wraps from CHANNELS-1 to 0.
- **Frame completion**
  - Accepting the sample at slot CHANNELS-1 copies staging (including that sample) into out_data and pulses out_valid.
  - Between completions, out_data holds its value.
- **Early sync:** accepted in_sync=1 while sel!=0.
  - sync_err pulses.
  - The partial frame is discarded and out_data is not updated.
  - The sample is taken as channel 0, sel=1, and the state stays LOCK.
- **Missing sync:** accepted in_sync=0 while sel==0.
  - sync_err pulses.
  - The sample is discarded, sel stays 0, and the state goes to HUNT.
- **Stalls:** in_valid=0 freezes all state; there is no timeout.
- **CHANNELS=1:** every accepted sync sample completes a frame. A non-sync sample in LOCK is a missing-sync error.
- Staging slots are only written, never cleared on error. Stale contents are harmless because a frame only completes after every slot has been rewritten.

## Timing
- All outputs are registered.
- Reset values: out_data=0, out_valid=0, sel=0, locked=0, sync_err=0, err_cnt=0. All staging registers are also 0.
- Latency: out_valid and the new out_data appear on the same edge that accepts the last slot sample. They are visible in the cycle after that sample is presented.
- Sustained throughput is one sample per clock.
- out_valid pulses are at least CHANNELS cycles apart.
- sync_err and out_valid never pulse in the same cycle.
- Reset asserted mid-frame takes effect immediately and asynchronously: all outputs return to their reset values and the partial frame is lost. After rst_n deasserts, the block is in HUNT.

## Configuration
- Macro: TDM_DEMUX_ERR_CNT_EN.
- **Defined:** err_cnt is an 8-bit saturating count of sync_err pulses.
  - It increments on each pulse and holds at 255.
  - It clears only on reset.
- **Undefined:** the err_cnt port and its logic are absent. All other behaviour is identical.

## Structure
- Package tdm_demux_pkg holds:
  - the state encoding, HUNT=1'b0 and LOCK=1'b1;
  - the SEL_W width function, max(1, clog2(CHANNELS));
  - the err_cnt width constant, 8.
- Sub-module decoder1_n (parameter N) is the combinational 1-of-N decoder.
  - It turns sel plus a write-enable into one-hot staging-register write enables.
  - It is the structural counterpart of the team's mux2_1-based selection.

## Test plan
All scenarios use CHANNELS=4, WIDTH=8.
- **Clean frame:** after reset, send 0x11(sync), 0x22, 0x33, 0x44 on back-to-back cycles. Expect one out_valid pulse with out_data=0x44332211, and locked=1 from the cycle after 0x11.
- **Stalls:** send the same frame with in_valid=0 for 3 cycles between each sample. Expect the identical out_data, a single out_valid, and sel frozen during each gap.
- **Early sync:** send 0xA0(sync), 0xA1, then 0xB0(sync), 0xB1, 0xB2, 0xB3. Expect sync_err for one cycle at 0xB0, no frame output for the A frame, then out_data=0xB3B2B1B0.
- **Missing sync:** send a valid frame, then 0x55 with in_sync=0 at slot 0. Expect a sync_err pulse, then locked=0 and sel=0. Non-sync samples that follow are ignored until the next sync.
- **Reset mid-frame:** send 0x01(sync), 0x02, assert rst_n=0 asynchronously between edges, release, then send a full frame 0x0A..0x0D. Expect all outputs at 0 immediately on reset, then out_data=0x0D0C0B0A.
- **Counter saturation** (with TDM_DEMUX_ERR_CNT_EN): force 300 missing-sync errors. Expect err_cnt=255, holding.
